dzcpu_useq: RTL

- Parametrised microcode sequencer for the dzcpu core. Replaces the fixed opcode-to-flow case tables with run-time programmable dispatch LUTs.
- Owns the micro-PC (uPC) and drives the external microcode ROM address. Decodes the ROM's control field for flow end, conditional end and prefix dispatch.
- Adds interrupt-flow insertion, memory-stall holding and uPC overflow fault detection.
- Sits between the fetch stage (opcode bytes in) and the datapath (uops out).

---
 rtl/dzcpu_useq_pkg.sv | 19 +
 rtl/dzcpu_flow_lut.sv | 33 +++
 rtl/dzcpu_useq.sv | 111 +++++++++++
 3 files changed

// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg: control-field encodings, sequencer states and flow-end decode
package dzcpu_useq_pkg;
  localparam logic [3:0] CTL_OP      = 4'd0;
  localparam logic [3:0] CTL_INC     = 4'd1;
  localparam logic [3:0] CTL_EOF     = 4'd2;
  localparam logic [3:0] CTL_INC_EOF = 4'd3;
  localparam logic [3:0] CTL_EOF_Z   = 4'd4;
  localparam logic [3:0] CTL_EOF_NZ  = 4'd5;
  localparam logic [3:0] CTL_EOF_C   = 4'd6;
  localparam logic [3:0] CTL_EOF_NC  = 4'd7;
  localparam logic [3:0] CTL_JCB     = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAITCB, S_HALT} state_e;
  // True when the control field terminates the flow under the given flags.
  function automatic logic is_end(input logic [3:0] ctrl, input logic z, input logic c);
    return (ctrl == CTL_EOF) || (ctrl == CTL_INC_EOF) ||
           (ctrl == CTL_EOF_Z && z) || (ctrl == CTL_EOF_NZ && !z) ||
           (ctrl == CTL_EOF_C && c) || (ctrl == CTL_EOF_NC && !c);
  endfunction
endpackage

// File: rtl/dzcpu_flow_lut.sv
// dzcpu_flow_lut: banked opcode-to-flow register file, one write port, one combinational read port
// Ports: clk_i/rst_ni (async active-low reset to DEFAULT_FLOW), we_i/wr_bank_i/wr_addr_i/wr_data_i write,
//        rd_bank_i/rd_addr_i in, flow_o out.
module dzcpu_flow_lut #(
  parameter int MOP_W = 8,
  parameter int UPC_W = 9,
  parameter int NUM_BANKS = 2,
  parameter int DEFAULT_FLOW = 0,
  localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic [MOP_W-1:0]  wr_addr_i,
  input  logic [UPC_W-1:0]  wr_data_i,
  input  logic [BANK_W-1:0] rd_bank_i,
  input  logic [MOP_W-1:0]  rd_addr_i,
  output logic [UPC_W-1:0]  flow_o
);
  logic [UPC_W-1:0] mem_q [NUM_BANKS][2**MOP_W];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int a = 0; a < 2**MOP_W; a++)
          mem_q[b][a] <= UPC_W'(DEFAULT_FLOW);
    end else if (we_i && 32'(wr_bank_i) < NUM_BANKS) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end
  // Out-of-range banks (non power-of-two bank counts) read as the default flow.
  assign flow_o = 32'(rd_bank_i) < NUM_BANKS ? mem_q[rd_bank_i][rd_addr_i] : UPC_W'(DEFAULT_FLOW);
endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: programmable microcode sequencer with IRQ insertion, stall hold and uPC overflow fault
// Ports: iClock/iReset (async active-low); iMop/iMopValid/oMopReady fetch side; iUop/oUpc ROM side;
//        oUop/oUopValid datapath side; iStall, iFlagZ/iFlagC, iIrqReq/oIrqAck; iLut* LUT write;
//        oFault sticky overflow; oBusy not idle.
module dzcpu_useq import dzcpu_useq_pkg::*; #(
  parameter int MOP_W = 8,
  parameter int UPC_W = 9,
  parameter int UOP_W = 13,
  parameter int CTL_W = 4,
  parameter int NUM_BANKS = 2,
  parameter int DEFAULT_FLOW = 0,
  parameter int IRQ_FLOW = 200,
  localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [MOP_W-1:0]  iMop,
  input  logic              iMopValid,
  output logic              oMopReady,
  input  logic [UOP_W-1:0]  iUop,
  output logic [UPC_W-1:0]  oUpc,
  output logic [UOP_W-1:0]  oUop,
  output logic              oUopValid,
  input  logic              iStall,
  input  logic              iFlagZ,
  input  logic              iFlagC,
  input  logic              iIrqReq,
  output logic              oIrqAck,
  input  logic              iLutWe,
  input  logic [BANK_W-1:0] iLutBank,
  input  logic [MOP_W-1:0]  iLutAddr,
  input  logic [UPC_W-1:0]  iLutData,
  output logic              oFault,
  output logic              oBusy
);
  state_e state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d, lut_flow;
  logic ack_q, ack_d, fault_q, fault_d;
  logic [3:0] ctrl;
  logic jcb, fin;
  // The single read port serves both dispatch points: bank 1 only while waiting for the CB byte.
  dzcpu_flow_lut #(.MOP_W(MOP_W), .UPC_W(UPC_W), .NUM_BANKS(NUM_BANKS), .DEFAULT_FLOW(DEFAULT_FLOW)) u_lut (
    .clk_i(iClock), .rst_ni(iReset), .we_i(iLutWe), .wr_bank_i(iLutBank), .wr_addr_i(iLutAddr),
    .wr_data_i(iLutData), .rd_bank_i(BANK_W'(state_q == S_WAITCB)), .rd_addr_i(iMop), .flow_o(lut_flow)
  );
  assign ctrl = 4'(iUop[UOP_W-1 -: CTL_W]);
  assign jcb  = ctrl == CTL_JCB;
  // With a single bank there is no prefix table, so JCB simply ends the flow.
  assign fin  = is_end(ctrl, iFlagZ, iFlagC) || (jcb && NUM_BANKS == 1);
  always_comb begin
    state_d = state_q;
    upc_d = upc_q;
    ack_d = 1'b0;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (iIrqReq) begin
          upc_d = UPC_W'(IRQ_FLOW);
          ack_d = 1'b1;
          state_d = S_RUN;
        end else if (iMopValid) begin
          upc_d = lut_flow;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!iStall) begin
          if (fin) begin
            upc_d = iIrqReq ? UPC_W'(IRQ_FLOW) : upc_q;
            ack_d = iIrqReq;
            state_d = iIrqReq ? S_RUN : S_IDLE;
          end else if (jcb) begin
            state_d = S_WAITCB;
          end else if (&upc_q) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            upc_d = upc_q + 1'b1;
          end
        end
      end
      S_WAITCB: begin
        if (iMopValid) begin
          upc_d = lut_flow;
          state_d = S_RUN;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      upc_q <= '0;
      ack_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q <= upc_d;
      ack_q <= ack_d;
      fault_q <= fault_d;
    end
  end
  assign oUpc = upc_q;
  assign oUop = iUop;
  assign oUopValid = state_q == S_RUN && !iStall;
  assign oMopReady = state_q == S_IDLE || state_q == S_WAITCB;
  assign oBusy = state_q != S_IDLE;
  assign oIrqAck = ack_q;
  assign oFault = fault_q;
endmodule
